// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prefix stall vector, registered flush with redirect PC,
// post-flush fetch bubble, saturating stall statistics and a stall-deadlock watchdog.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_RUN    | normal operation, stall = prefix of stall_req
// S_FLUSH  | one-cycle flush of all pipeline registers, stall forced to 0
// S_BUBBLE | PC held for BUBBLE_CYC cycles after a flush
module pipe_ctrl #(
  parameter int STAGES     = 6,
  parameter int BUBBLE_CYC = 1,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  input  logic              clr_stats,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic              timeout
);

  localparam int BUB_W = (BUBBLE_CYC > 0) ? $clog2(BUBBLE_CYC + 1) : 1;
  localparam int RUN_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BUB_W-1:0] BUB_LOAD = BUB_W'(BUBBLE_CYC);
  localparam logic [BUB_W-1:0] BUB_ONE  = BUB_W'(1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(TIMEOUT);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_BUBBLE} state_t;

  state_t            state_q;
  logic              flush_q;
  logic [31:0]       new_pc_q;
  logic [BUB_W-1:0]  bub_cnt_q;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              timeout_q, timeout_d;
  logic [STAGES-1:0] prefix;
  logic [STAGES-1:0] stall_vec;
  logic              any_req;
  logic              stalled;

  // Every stage at or below the highest requesting stage must hold.
  always_comb begin
    prefix  = '0;
    any_req = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      any_req   = any_req | stall_req[i];
      prefix[i] = any_req;
    end
    stall_vec = prefix;
    if (state_q == S_FLUSH) begin
      stall_vec = '0;
    end else if (state_q == S_BUBBLE) begin
      stall_vec[0] = 1'b1;
    end
  end

  assign stalled = |stall_vec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_RUN;
      flush_q   <= 1'b0;
      new_pc_q  <= '0;
      bub_cnt_q <= '0;
    end else if (flush_req) begin
      state_q   <= S_FLUSH;
      flush_q   <= 1'b1;
      new_pc_q  <= flush_pc;
      bub_cnt_q <= BUB_LOAD;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        S_FLUSH:  state_q <= (BUBBLE_CYC > 0) ? S_BUBBLE : S_RUN;
        S_BUBBLE: begin
          if (bub_cnt_q == BUB_ONE) state_q <= S_RUN;
          else                      bub_cnt_q <= bub_cnt_q - BUB_ONE;
        end
        default:  state_q <= S_RUN;
      endcase
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (clr_stats) begin
      stall_cycles_d = '0;
    end else if (stalled && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end

    // Run length of consecutive stalled cycles, pinned at TIMEOUT once reached.
    run_d = '0;
    if (!clr_stats && stalled) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
    end

    timeout_d = timeout_q;
    if (clr_stats) begin
      timeout_d = 1'b0;
    end else if ((TIMEOUT > 0) && stalled && (run_d == RUN_MAX)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      run_q          <= '0;
      timeout_q      <= 1'b0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      run_q          <= run_d;
      timeout_q      <= timeout_d;
    end
  end

  assign stall        = stall_vec;
  assign flush        = flush_q;
  assign new_pc       = new_pc_q;
  assign stall_cycles = stall_cycles_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: two instances share stimulus, one with a 1-cycle bubble
// and 4-cycle watchdog, the other with a 3-cycle bubble and a 4-bit statistics counter.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall_req = '0;
  logic        flush_req = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        clr_stats = 1'b0;

  logic [5:0]  a_stall, b_stall;
  logic        a_flush, b_flush;
  logic [31:0] a_new_pc, b_new_pc;
  logic [31:0] a_stall_cycles;
  logic [3:0]  b_stall_cycles;
  logic        a_timeout, b_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.STAGES(6), .BUBBLE_CYC(1), .CNT_W(32), .TIMEOUT(4)) u_dut_a (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
    .flush_pc(flush_pc), .clr_stats(clr_stats), .stall(a_stall), .flush(a_flush),
    .new_pc(a_new_pc), .stall_cycles(a_stall_cycles), .timeout(a_timeout)
  );

  pipe_ctrl #(.STAGES(6), .BUBBLE_CYC(3), .CNT_W(4), .TIMEOUT(0)) u_dut_b (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
    .flush_pc(flush_pc), .clr_stats(clr_stats), .stall(b_stall), .flush(b_flush),
    .new_pc(b_new_pc), .stall_cycles(b_stall_cycles), .timeout(b_timeout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall_req = '0;
    flush_req = 1'b0;
    flush_pc  = '0;
    clr_stats = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    #1;
    check("rst_flush",   a_flush, 0);
    check("rst_new_pc",  a_new_pc, 0);
    check("rst_cnt",     a_stall_cycles, 0);
    check("rst_timeout", a_timeout, 0);
    check("rst_stall",   a_stall, 0);

    // Prefix stall
    stall_req = 6'b000100; #1 check("prefix_b2", a_stall, 6'b000111);
    tick(); check("cnt_1", a_stall_cycles, 1);
    stall_req = 6'b001010; #1 check("prefix_b3", a_stall, 6'b001111);
    tick();
    stall_req = 6'b100000; #1 check("prefix_b5", b_stall, 6'b111111);
    tick(); check("cnt_3", a_stall_cycles, 3);
    stall_req = 6'b000000; #1 check("prefix_zero", a_stall, 6'b000000);
    tick();
    stall_req = 6'b000001; #1 check("prefix_b0", a_stall, 6'b000001);
    tick(); check("cnt_4", a_stall_cycles, 4);
    check("no_timeout_gap", a_timeout, 0);

    // Flush + bubble
    do_reset();
    flush_req = 1'b1; flush_pc = 32'h0000_0180;
    #1 check("flush_not_yet", a_flush, 0);
    tick();
    flush_req = 1'b0; stall_req = 6'b001000;
    #1 check("flush_t1", a_flush, 1);
    check("new_pc_t1", a_new_pc, 32'h180);
    check("flush_stall0", a_stall, 0);
    tick();
    stall_req = '0;
    #1 check("bubble_a", a_stall, 6'b000001);
    check("flush_low_t2", a_flush, 0);
    check("bubble_b1", b_stall, 6'b000001);
    tick();
    check("run_a", a_stall, 0);
    check("cnt_bubble_a", a_stall_cycles, 1);
    check("bubble_b2", b_stall, 6'b000001);
    tick(); check("bubble_b3", b_stall, 6'b000001);
    tick(); check("run_b", b_stall, 0);
    check("cnt_bubble_b", b_stall_cycles, 3);

    // Back-to-back flush, then flush during bubble
    do_reset();
    flush_req = 1'b1; flush_pc = 32'h100;
    tick();
    flush_pc = 32'h200;
    #1 check("b2b_flush1", a_flush, 1);
    check("b2b_pc1", a_new_pc, 32'h100);
    tick();
    flush_req = 1'b0;
    #1 check("b2b_flush2", a_flush, 1);
    check("b2b_pc2", a_new_pc, 32'h200);
    tick();
    check("b2b_flush_end", a_flush, 0);
    check("b2b_bubble", a_stall, 6'b000001);
    flush_req = 1'b1; flush_pc = 32'h300;
    tick();
    flush_req = 1'b0;
    #1 check("bub_flush_a", a_flush, 1);
    check("bub_flush_pc", a_new_pc, 32'h300);
    check("bub_flush_stall", a_stall, 0);
    tick(); check("bub2_a", a_stall, 6'b000001);
    tick(); check("bub2_a_end", a_stall, 0);
    tick(); check("reload_b", b_stall, 6'b000001);
    tick(); check("reload_b_end", b_stall, 0);

    // Watchdog, TIMEOUT=4
    do_reset();
    for (int r = 0; r < 2; r++) begin
      stall_req = 6'b000001;
      for (int i = 0; i < 3; i++) tick();
      stall_req = '0;
      tick();
    end
    check("wd_gap", a_timeout, 0);
    stall_req = 6'b000001;
    for (int i = 0; i < 3; i++) tick();
    check("wd_3", a_timeout, 0);
    tick(); check("wd_4", a_timeout, 1);
    stall_req = '0;
    tick(); check("wd_sticky", a_timeout, 1);
    check("wd_cnt", a_stall_cycles, 10);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("wd_clr", a_timeout, 0);
    check("wd_cnt_clr", a_stall_cycles, 0);

    // Async reset mid-bubble
    do_reset();
    flush_req = 1'b1; flush_pc = 32'h44;
    tick();
    flush_req = 1'b0;
    #1 check("ar_pc", b_new_pc, 32'h44);
    tick(); tick();
    check("ar_bubble", b_stall, 6'b000001);
    #2 rst = 1'b0;
    #1 check("ar_stall", b_stall, 0);
    check("ar_new_pc", b_new_pc, 0);
    check("ar_flush", b_flush, 0);
    check("ar_cnt", b_stall_cycles, 0);
    stall_req = 6'b000100;
    #1 check("ar_prefix", b_stall, 6'b000111);
    #1 rst = 1'b1;
    stall_req = '0;
    tick(); check("ar_run", b_stall, 0);

    // Saturation, CNT_W=4
    do_reset();
    stall_req = 6'b000001;
    for (int i = 0; i < 20; i++) tick();
    check("sat", b_stall_cycles, 4'hF);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("sat_clr", b_stall_cycles, 0);
    tick(); check("sat_after", b_stall_cycles, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline hazard controller for the CPU core. It turns per-stage stall requests into a prefix stall vector across all pipeline registers, just as the existing stall control does. It adds registered exception flushes with a redirect PC, a programmable post-flush fetch bubble, stall-cycle statistics and a stall-deadlock watchdog. It sits beside the pipeline and drives the stall and flush inputs of every pipeline register and of the PC register.

## Interface
- STAGES, 6: number of pipeline control points; bit 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB, 5 = WB.
- BUBBLE_CYC, 1: cycles PC is held after a flush; 0 disables the bubble.
- CNT_W, 32: width of the stall statistics counter.
- TIMEOUT, 1024: consecutive stalled cycles that trip the watchdog; 0 disables it.

- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- stall_req  in  STAGES  bit i = stage i requests a stall this cycle
- flush_req  in  1  exception/redirect request, single-cycle qualifier
- flush_pc  in  32  redirect target, valid with flush_req
- clr_stats  in  1  synchronous clear of stall_cycles and timeout
- stall  out  STAGES  stall vector to pipeline registers
- flush  out  1  flush all pipeline registers this cycle
- new_pc  out  32  redirect PC, valid while flush = 1
- stall_cycles  out  CNT_W  saturating count of cycles with stall != 0
- timeout  out  1  sticky watchdog flag

## Operation
- Stall vector (combinational from stall_req and state):
  - k = index of the highest set stall_req bit.
  - stall = bits [k:0] set, upper bits clear. stall_req = 0 gives stall = 0.
  - For STAGES=6: req bit 2 → 6'b000111; req bit 3 → 6'b001111.
- FSM states RUN, FLUSH, BUBBLE; reset state RUN.
  - RUN: flush_req=1 → FLUSH next cycle, flush_pc captured into new_pc.
  - FLUSH: lasts exactly one cycle; flush=1; stall forced to 0 (flush overrides every stall request).
  - FLUSH exit: → BUBBLE if BUBBLE_CYC>0, else → RUN.
  - flush_req during FLUSH → FLUSH again with the newly captured pc (back-to-back flushes allowed).
  - BUBBLE: lasts BUBBLE_CYC cycles, counted by a down-counter loaded on FLUSH entry. stall bit 0 forced to 1. Other bits follow the normal prefix rule (k ≥ 0 always).
  - flush_req during BUBBLE → FLUSH (flush has priority); the bubble counter reloads on that FLUSH.
- Statistics:
  - stall_cycles increments in any cycle where the stall output != 0, including BUBBLE cycles.
  - It saturates at all-ones.
  - clr_stats=1 forces it to 0 next edge; clear wins over a simultaneous increment.
- Watchdog:
  - An internal run counter increments while stall != 0 and resets to 0 on any cycle with stall = 0, including FLUSH cycles.
  - When the run counter reaches TIMEOUT, timeout is set and stays 1 until clr_stats or reset.
  - clr_stats also clears the run counter.
- Reset (rst=0, asynchronous):
  - state=RUN, flush=0, new_pc=0, stall_cycles=0, timeout=0, run and bubble counters 0.
  - The stall output then reflects only stall_req.
  - A reset asserted mid-FLUSH or mid-BUBBLE aborts immediately.

## Timing
- stall: zero-latency combinational, so pipeline registers see it in the same cycle as the request.
- flush/new_pc: registered, with one cycle of latency from flush_req. flush is high for exactly one cycle per accepted request.
- BUBBLE occupies the BUBBLE_CYC cycles immediately after the FLUSH cycle.
- flush_req is sampled every cycle; none are dropped.
- stall_cycles and timeout update on the edge following the qualifying cycle.
- With TIMEOUT=N, timeout rises on the edge ending the Nth consecutive stalled cycle.

## Test plan
- Prefix stall: stall_req=6'b000100 → stall=6'b000111; stall_req=6'b001010 → 6'b001111; stall_req=0 → 0. All same cycle, stall_cycles +1 per stalled cycle.
- Flush + bubble, BUBBLE_CYC=1:
  - flush_req=1, flush_pc=32'h0000_0180 at cycle t.
  - Cycle t+1: flush=1, new_pc=32'h180, stall=0 even with stall_req=6'b001000.
  - Cycle t+2: stall[0]=1.
  - Cycle t+3: back to RUN.
- Back-to-back flush: flush_req at t with pc 0x100 and at t+1 with pc 0x200 → flush=1 at t+1 (new_pc=0x100) and t+2 (new_pc=0x200), then one bubble cycle.
- Watchdog, TIMEOUT=4:
  - stall_req=1 for 3 cycles, a gap, then 3 more → timeout stays 0.
  - 4 consecutive stalled cycles → timeout=1, still 1 after stall_req drops.
  - clr_stats → timeout=0, stall_cycles=0.
- Async reset mid-BUBBLE (BUBBLE_CYC=3), rst low between edges → outputs clear immediately, stall = prefix of stall_req only. After release, behaviour is RUN.
- Saturation, CNT_W=4: 20 stalled cycles → stall_cycles=4'hF. clr_stats together with a stalled cycle → 0.
